// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: skips N vsync falling edges, then writes one frame of active pixels to a linear buffer.
// Optional FRAME_CAP_GEOM_CHECK_EN adds a sticky line-length / line-count check on the captured frame.
module frame_capture_ctrl #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int ADDR_W    = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              video_vsync,
    input  logic              video_hsync,
    input  logic              video_de,
    input  logic [23:0]       video_data,
    input  logic              cap_start,
    input  logic [7:0]        cap_skip,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic [11:0]       frame_cnt,
    output logic              err_geom
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_CAP = 2'd2, S_DONE = 2'd3;
    localparam int N = IMG_HDISP * IMG_VDISP;

    logic [1:0]        state_q, state_d;
    logic              vsync_d1_q;
    logic [7:0]        skip_q, skip_d;
    logic [ADDR_W-1:0] pix_q, pix_d, wr_addr_q, wr_addr_d;
    logic [23:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d, cap_done_q, cap_done_d;
    logic [11:0]       frame_cnt_q, frame_cnt_d;
    logic              fe, wr_now, unused_hsync;

    assign fe           = vsync_d1_q & ~video_vsync;
    // a boundary takes priority over de in the same cycle
    assign wr_now       = state_q == S_CAP && video_de && !fe;
    assign unused_hsync = video_hsync;

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        pix_d       = pix_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = wr_now;
        cap_done_d  = state_q == S_DONE;
        frame_cnt_d = frame_cnt_q + 12'(fe);
        case (state_q)
            S_IDLE: if (cap_start) begin
                skip_d  = cap_skip;
                state_d = S_ARM;
            end
            S_ARM: if (fe) begin
                if (skip_q == 8'd0) begin
                    state_d = S_CAP;
                    pix_d   = '0;
                end else skip_d = skip_q - 8'd1;
            end
            S_CAP: if (fe) state_d = S_DONE;
            else if (video_de) begin
                wr_addr_d = pix_q;
                wr_data_d = video_data;
                state_d   = pix_q == ADDR_W'(N - 1) ? S_DONE : S_CAP;
                pix_d     = pix_q == ADDR_W'(N - 1) ? pix_q : pix_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vsync_d1_q  <= 1'b0;
            skip_q      <= '0;
            pix_q       <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            cap_done_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vsync_d1_q  <= video_vsync;
            skip_q      <= skip_d;
            pix_q       <= pix_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            cap_done_q  <= cap_done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cap_busy  = state_q != S_IDLE;
    assign cap_done  = cap_done_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_cnt = frame_cnt_q;

`ifdef FRAME_CAP_GEOM_CHECK_EN
    logic [15:0] run_q, run_d, line_q, line_d;
    logic        err_q, err_d, end_run;

    // the last line's run closes in DONE, so DONE counts it as a finished line
    assign end_run = (state_q == S_CAP || state_q == S_DONE) && run_q != 16'd0 && !wr_now;

    always_comb begin
        run_d  = run_q;
        line_d = line_q;
        err_d  = err_q;
        if (state_q == S_IDLE && cap_start) err_d = 1'b0;
        if (state_q == S_ARM) begin
            run_d  = '0;
            line_d = '0;
        end
        if (wr_now) run_d = run_q + 16'd1;
        else if (end_run) begin
            run_d  = '0;
            line_d = line_q + 16'd1;
            if (run_q != 16'(IMG_HDISP)) err_d = 1'b1;
        end
        if (state_q == S_DONE && line_q + 16'(run_q != 16'd0) != 16'(IMG_VDISP)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            line_q <= line_d;
            err_q  <= err_d;
        end
    end

    assign err_geom = err_q;
`else
    assign err_geom = 1'b0;
`endif
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb_frame_capture_ctrl: directed frames on a 4x2 geometry; writes and done pulses are logged and compared.
module tb_frame_capture_ctrl;
    localparam int H = 4, V = 2, AW = 3;
`ifdef FRAME_CAP_GEOM_CHECK_EN
    localparam int GEOM = 1;
`else
    localparam int GEOM = 0;
`endif

    logic          clk = 1'b0, rst_n = 1'b1;
    logic          video_vsync = 1'b0, video_hsync = 1'b0, video_de = 1'b0, cap_start = 1'b0;
    logic [23:0]   video_data = '0;
    logic [7:0]    cap_skip = '0;
    logic          cap_busy, cap_done, wr_en, err_geom;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic [11:0]   frame_cnt;

    frame_capture_ctrl #(.IMG_HDISP(H), .IMG_VDISP(V), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .video_vsync(video_vsync), .video_hsync(video_hsync),
        .video_de(video_de), .video_data(video_data), .cap_start(cap_start), .cap_skip(cap_skip),
        .cap_busy(cap_busy), .cap_done(cap_done), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_cnt(frame_cnt), .err_geom(err_geom)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, fid = 0, fc_exp = 0;
    int wa[$], wd[$], wc[$], wf[$], dc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(int'(wr_addr));
            wd.push_back(int'(wr_data));
            wc.push_back(cyc);
            wf.push_back(int'(frame_cnt));
        end
        if (cap_done) dc.push_back(cyc);
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); wf.delete(); dc.delete();
    endtask

    // frame = 3 vsync-high cycles, fe, 2 blanks, line0 (l0 px), 2 blanks, line1 (l1 px), 2 blanks
    task automatic send_frame(input int l0, input int l1, input int st, input int rs, input int sk);
        int px = 0;
        video_de = 1'b0;
        video_vsync = 1'b1;
        repeat (3) step();
        video_vsync = 1'b0;
        fc_exp++;
        repeat (2) step();
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < (l == 0 ? l0 : l1); p++) begin
                video_de   = 1'b1;
                video_data = {fid[7:0], 8'(l), 8'(p)};
                cap_start  = px == st;
                cap_skip   = 8'(sk);
                if (px == rs) begin
                    @(negedge clk);
                    #1 rst_n = 1'b0;
                    fc_exp = 0;
                    #1;
                    check("rst_wr_en", wr_en, 0);
                    check("rst_wr_addr", wr_addr, 0);
                    check("rst_wr_data", wr_data, 0);
                    check("rst_cap_done", cap_done, 0);
                    check("rst_cap_busy", cap_busy, 0);
                    check("rst_frame_cnt", frame_cnt, 0);
                    check("rst_err_geom", err_geom, 0);
                    step();
                    rst_n = 1'b1;
                end else step();
                px++;
            end
            video_de    = 1'b0;
            cap_start   = 1'b0;
            video_hsync = 1'b1;
            step();
            video_hsync = 1'b0;
            step();
        end
        fid++;
    endtask

    task automatic check_cap(input string tag, input int f, input int l0, input int n);
        check($sformatf("%s_nwr", tag), wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa[i], i);
            check($sformatf("%s_data%0d", tag, i), wd[i],
                  ((f & 255) << 16) | ((i < l0 ? 0 : 1) << 8) | (i < l0 ? i : i - l0));
        end
    endtask

    initial begin
        int f0, fcs;
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("init_frame_cnt", frame_cnt, 0);
        check("init_busy", cap_busy, 0);

        // reset in the middle of a frame clears the boundary count
        send_frame(4, 4, -1, -1, 0);
        check("t1_frame_cnt", frame_cnt, fc_exp);
        send_frame(4, 4, -1, 2, 0);
        check("t1_frame_cnt_after_rst", frame_cnt, 0);

        // skip 0: the frame after the request is captured
        clear_log();
        f0 = fid;
        send_frame(4, 4, 2, -1, 0);
        check("t2_busy_armed", cap_busy, 1);
        send_frame(4, 4, -1, -1, 0);
        check_cap("t2", f0 + 1, 4, 8);
        check("t2_ndone", dc.size(), 1);
        if (dc.size() > 0 && wc.size() > 0) check("t2_done_lat", dc[0] - wc[wc.size() - 1], 1);
        check("t2_busy_end", cap_busy, 0);
        check("t2_frame_cnt", frame_cnt, fc_exp);

        // skip 2: third following frame captured, frame_cnt +3 at that point
        clear_log();
        f0 = fid;
        send_frame(4, 4, 2, -1, 2);
        fcs = fc_exp;
        repeat (3) send_frame(4, 4, -1, -1, 0);
        check_cap("t3", f0 + 3, 4, 8);
        if (wf.size() > 0) check("t3_fc_at_cap", wf[0], fcs + 3);
        check("t3_ndone", dc.size(), 1);

        // short frame: 5 pixels then a boundary
        clear_log();
        f0 = fid;
        send_frame(4, 4, 2, -1, 0);
        send_frame(4, 1, -1, -1, 0);
        send_frame(4, 4, -1, -1, 0);
        check_cap("t4", f0 + 1, 4, 5);
        check("t4_ndone", dc.size(), 1);
        check("t4_err_geom", err_geom, GEOM);
        check("t4_busy", cap_busy, 0);

        // cap_start during CAPTURE ignored
        clear_log();
        f0 = fid;
        send_frame(4, 4, 2, -1, 0);
        send_frame(4, 4, 3, -1, 7);
        send_frame(4, 4, -1, -1, 0);
        check_cap("t5a", f0 + 1, 4, 8);
        check("t5a_ndone", dc.size(), 1);
        check("t5a_busy", cap_busy, 0);

        // reset at pixel 3 aborts silently
        clear_log();
        f0 = fid;
        send_frame(4, 4, 2, -1, 0);
        send_frame(4, 4, -1, 3, 0);
        check_cap("t5b", f0 + 1, 4, 3);
        check("t5b_ndone", dc.size(), 0);
        check("t5b_busy", cap_busy, 0);
        clear_log();
        f0 = fid;
        send_frame(4, 4, 2, -1, 0);
        send_frame(4, 4, -1, -1, 0);
        check_cap("t5c", f0 + 1, 4, 8);
        check("t5c_ndone", dc.size(), 1);

        // 3-pixel line: sticky geometry error until the next accepted start
        clear_log();
        f0 = fid;
        send_frame(4, 4, 2, -1, 0);
        send_frame(3, 4, -1, -1, 0);
        send_frame(4, 4, -1, -1, 0);
        check_cap("t6", f0 + 1, 3, 7);
        check("t6_err_geom", err_geom, GEOM);
        send_frame(4, 4, -1, -1, 0);
        check("t6_err_held", err_geom, GEOM);
        clear_log();
        f0 = fid;
        send_frame(4, 4, 2, -1, 0);
        check("t6_err_cleared", err_geom, 0);
        send_frame(4, 4, -1, -1, 0);
        check_cap("t6b", f0 + 1, 4, 8);
        check("t6b_err_geom", err_geom, 0);
        check("t6b_ndone", dc.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
